// File: rtl/writedest_pkg.sv
// writedest_pkg: shared widths, buffer entry layout and write FSM encoding for writedest
package writedest_pkg;
   localparam int PIX_W  = 24;
   localparam int ADDR_W = 30;
   localparam int CNT_W  = 20;
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [PIX_W-1:0]  data;
   } entry_t;
   typedef enum logic {IDLE, WRITE} state_t;
endpackage

// File: rtl/writedest_fifo.sv
// writedest_fifo: pixel write buffer; 4-entry circular FIFO when WRITEDEST_FIFO_EN is defined, else one holding register
module writedest_fifo
   import writedest_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   push,
   input  logic   pop,
   input  entry_t din,
   output entry_t dout,
   output logic   full,
   output logic   empty
);
`ifdef WRITEDEST_FIFO_EN
   entry_t [3:0] mem_q, mem_d;
   logic [1:0]   wp_q, wp_d, rp_q, rp_d;
   logic [2:0]   level_q, level_d;
   // full/empty come from the registered level, so a pop frees space only from the next cycle
   always_comb begin
      mem_d = mem_q;
      if (push) mem_d[wp_q] = din;
      wp_d    = wp_q + 2'(push);
      rp_d    = rp_q + 2'(pop);
      level_d = level_q + 3'(push) - 3'(pop);
   end
   // buffer storage and pointers
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         mem_q   <= '0;
         wp_q    <= '0;
         rp_q    <= '0;
         level_q <= '0;
      end else begin
         mem_q   <= mem_d;
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         level_q <= level_d;
      end
   assign dout  = mem_q[rp_q];
   assign full  = level_q == 3'd4;
   assign empty = level_q == 3'd0;
`else
   entry_t hold_q, hold_d;
   logic   valid_q, valid_d;
   // a single slot: filled by push, released by pop
   always_comb begin
      hold_d  = push ? din : hold_q;
      valid_d = push | (valid_q & ~pop);
   end
   // holding register and its valid bit
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         hold_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         hold_q  <= hold_d;
         valid_q <= valid_d;
      end
   assign dout  = hold_q;
   assign full  = valid_q;
   assign empty = ~valid_q;
`endif
endmodule

// File: rtl/writedest.sv
// writedest: destination pixel write-back as a write-only WISHBONE master with frame counting (buffer depth via WRITEDEST_FIFO_EN)
module writedest
   import writedest_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CNT_W-1:0]  npixels,
   output logic              busy,
   output logic              done,
   input  logic              dc_ready,
   output logic              dc_next,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [PIX_W-1:0]  d_data,
   output logic [31:0]       mwb_adr_o,
   output logic [31:0]       mwb_dat_o,
   output logic [3:0]        mwb_sel_o,
   output logic              mwb_we_o,
   output logic              mwb_cyc_o,
   output logic              mwb_stb_o,
   input  logic              mwb_ack_i
);
   state_t            state_q, state_d;
   logic              stb_q, stb_d, busy_q, busy_d, done_q, done_d;
   logic [31:0]       adr_q, adr_d, dat_q, dat_d;
   logic [CNT_W-1:0]  remaining_q, remaining_d;
   logic              full, empty, pop, ack;
   entry_t            head;

   assign dc_next = dc_ready & ~full & ~rst;
   assign ack     = (state_q == WRITE) & mwb_ack_i;

   writedest_fifo u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (dc_next),
      .pop   (pop),
      .din   ({d_addr, d_data}),
      .dout  (head),
      .full  (full),
      .empty (empty)
   );

   // write FSM: load bus registers from the buffer head, then hold them until acknowledged
   always_comb begin
      state_d = state_q;
      stb_d   = stb_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      pop     = 1'b0;
      if (state_q == IDLE) begin
         if (!empty) begin
            pop     = 1'b1;
            adr_d   = {head.addr, 2'b00};
            dat_d   = {8'h00, head.data};
            stb_d   = 1'b1;
            state_d = WRITE;
         end
      end else if (mwb_ack_i) begin
         stb_d   = 1'b0;
         state_d = IDLE;
      end
   end

   // frame counter: acks are counted only inside a frame; an empty frame completes at once
   always_comb begin
      busy_d      = busy_q;
      remaining_d = remaining_q;
      done_d      = 1'b0;
      if (start && !busy_q) begin
         remaining_d = npixels;
         busy_d      = npixels != '0;
         done_d      = npixels == '0;
      end else if (ack && busy_q) begin
         remaining_d = remaining_q - CNT_W'(1);
         if (remaining_q == CNT_W'(1)) begin
            done_d = 1'b1;
            busy_d = 1'b0;
         end
      end
   end

   // state registers
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q     <= IDLE;
         stb_q       <= 1'b0;
         adr_q       <= '0;
         dat_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         remaining_q <= '0;
      end else begin
         state_q     <= state_d;
         stb_q       <= stb_d;
         adr_q       <= adr_d;
         dat_q       <= dat_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         remaining_q <= remaining_d;
      end

   assign mwb_adr_o = adr_q;
   assign mwb_dat_o = dat_q;
   assign mwb_sel_o = 4'b1111;
   assign mwb_stb_o = stb_q;
   assign mwb_cyc_o = stb_q;
   assign mwb_we_o  = stb_q;
   assign busy      = busy_q;
   assign done      = done_q;
endmodule

// File: tb/tb_writedest.sv
// tb_writedest: directed table-driven and sequence checks for writedest (default or WRITEDEST_FIFO_EN build)
`timescale 1ns/1ps
module tb_writedest;
   logic        clk = 0, rst = 1, start = 0, dc_ready = 0, mwb_ack_i = 0;
   logic [19:0] npixels = '0;
   logic [29:0] d_addr = '0;
   logic [23:0] d_data = '0;
   logic        busy, done, dc_next, mwb_we_o, mwb_cyc_o, mwb_stb_o;
   logic [31:0] mwb_adr_o, mwb_dat_o;
   logic [3:0]  mwb_sel_o;

   int tests = 0, fails = 0;
   int ack_wait = 0, cyc = 0, done_cnt = 0, wcnt = 0;
   bit slave_en = 1;
   logic [63:0] held = '0;

   typedef struct {
      logic [31:0] adr;
      logic [31:0] dat;
      logic        done;
      logic        busy;
      int          cyc;
   } rec_t;
   rec_t wr_q[$];

   typedef struct {
      logic [29:0] addr;
      logic [23:0] data;
      int          wait_n;
      logic [31:0] adr;
      logic [31:0] dat;
   } vec_t;

`ifdef WRITEDEST_FIFO_EN
   localparam int STALL_AT = 5, RST_PUSH = 4;
`else
   localparam int STALL_AT = 1, RST_PUSH = 2;
`endif

   always #5 clk = ~clk;

   writedest dut (
      .clk(clk), .rst(rst), .start(start), .npixels(npixels), .busy(busy), .done(done),
      .dc_ready(dc_ready), .dc_next(dc_next), .d_addr(d_addr), .d_data(d_data),
      .mwb_adr_o(mwb_adr_o), .mwb_dat_o(mwb_dat_o), .mwb_sel_o(mwb_sel_o),
      .mwb_we_o(mwb_we_o), .mwb_cyc_o(mwb_cyc_o), .mwb_stb_o(mwb_stb_o), .mwb_ack_i(mwb_ack_i)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] exp_adr(input logic [29:0] base, input int i);
      logic [29:0] a;
      a = base + 30'(i);
      return {a, 2'b00};
   endfunction

   function automatic logic [23:0] pix(input int i);
      return 24'h5A0000 | 24'(i);
   endfunction

   // slave model plus write/done monitor, all at the falling edge
   always @(negedge clk) begin
      cyc++;
      if (done) done_cnt++;
      if (rst) begin
         mwb_ack_i = 0;
         wcnt = 0;
      end else if (mwb_ack_i) begin
         wr_q.push_back(rec_t'{mwb_adr_o, mwb_dat_o, done, busy, cyc});
         mwb_ack_i = 0;
         wcnt = 0;
      end else if (mwb_stb_o && slave_en) begin
         if (wcnt == 0) held = {mwb_adr_o, mwb_dat_o};
         else check("adr_dat_stable", {mwb_adr_o, mwb_dat_o}, held);
         if (wcnt >= ack_wait) mwb_ack_i = 1;
         else wcnt++;
      end
   end

   task automatic start_frame(input logic [19:0] n);
      @(negedge clk);
      start = 1;
      npixels = n;
      @(negedge clk);
      start = 0;
   endtask

   task automatic stream(input int n, input logic [29:0] base, output int acc, output int stall_at);
      acc = 0;
      stall_at = -1;
      for (int t = 0; t < 200 && acc < n; t++) begin
         @(negedge clk);
         dc_ready = 1;
         d_addr = base + 30'(acc);
         d_data = pix(acc);
         #1;
         if (dc_next) acc++;
         else if (stall_at < 0) stall_at = acc;
      end
      @(negedge clk);
      dc_ready = 0;
   endtask

   task automatic wait_writes(input int n);
      for (int t = 0; t < 500 && wr_q.size() < n; t++) @(posedge clk);
      check("write_count", wr_q.size(), n);
   endtask

   initial begin
      vec_t tbl[6];
      rec_t r;
      int   acc, st, d0;
      tbl[0] = '{30'h100,      24'hABCDEF, 0, 32'h0000_0400, 32'h00AB_CDEF};
      tbl[1] = '{30'h3FFFFFFF, 24'hFFFFFF, 1, 32'hFFFF_FFFC, 32'h00FF_FFFF};
      tbl[2] = '{30'h0,        24'h000000, 2, 32'h0000_0000, 32'h0000_0000};
      tbl[3] = '{30'h2AAAAAAA, 24'h555555, 0, 32'hAAAA_AAA8, 32'h0055_5555};
      tbl[4] = '{30'h12345678, 24'h123456, 3, 32'h48D1_59E0, 32'h0012_3456};
      tbl[5] = '{30'h15555555, 24'hAAAAAA, 1, 32'h5555_5554, 32'h00AA_AAAA};

      repeat (3) @(negedge clk);
      dc_ready = 1;
      #1;
      check("rst_dc_next", dc_next, 0);
      check("rst_busy_done", {busy, done}, 2'b00);
      check("rst_stb_cyc_we", {mwb_stb_o, mwb_cyc_o, mwb_we_o}, 3'b000);
      check("rst_adr", mwb_adr_o, 0);
      check("rst_dat", mwb_dat_o, 0);
      dc_ready = 0;
      @(negedge clk);
      rst = 0;

      foreach (tbl[i]) begin
         wr_q.delete();
         ack_wait = tbl[i].wait_n;
         d0 = done_cnt;
         start_frame(1);
         check("vec_busy_after_start", busy, 1);
         @(negedge clk);
         dc_ready = 1;
         d_addr = tbl[i].addr;
         d_data = tbl[i].data;
         #1;
         check("vec_dc_next_empty", dc_next, 1);
         @(negedge clk);
         dc_ready = 0;
         check("vec_stb_before_load", mwb_stb_o, 0);
         @(negedge clk);
         check("vec_stb_loaded", mwb_stb_o, 1);
         check("vec_bus_adr", mwb_adr_o, tbl[i].adr);
         check("vec_bus_dat", mwb_dat_o, tbl[i].dat);
         check("vec_cyc_we_sel", {mwb_cyc_o, mwb_we_o, mwb_sel_o}, {2'b11, 4'hF});
         wait_writes(1);
         if (wr_q.size() > 0) begin
            r = wr_q.pop_front();
            check("vec_wr_adr", r.adr, tbl[i].adr);
            check("vec_wr_dat", r.dat, tbl[i].dat);
            check("vec_done_busy_after_ack", {r.done, r.busy}, 2'b10);
         end
         repeat (3) @(negedge clk);
         #2;
         check("vec_done_once", done_cnt - d0, 1);
         check("vec_stb_idle", mwb_stb_o, 0);
      end

      // empty frame
      @(negedge clk);
      start = 1;
      npixels = 0;
      @(negedge clk);
      start = 0;
      check("zero_done", done, 1);
      check("zero_busy", busy, 0);
      @(negedge clk);
      check("zero_done_fall", {done, busy}, 2'b00);

      // stalling slave burst
      wr_q.delete();
      ack_wait = 3;
      d0 = done_cnt;
      start_frame(8);
      stream(8, 30'h200, acc, st);
      check("burst_accepted", acc, 8);
      check("burst_stall_at", st, STALL_AT);
      wait_writes(8);
      for (int i = 0; i < 8 && wr_q.size() > 0; i++) begin
         r = wr_q.pop_front();
         check("burst_adr", r.adr, exp_adr(30'h200, i));
         check("burst_dat", r.dat, {8'h00, pix(i)});
         check("burst_flags", {r.done, r.busy}, i == 7 ? 2'b10 : 2'b01);
      end
      check("burst_done_once", done_cnt - d0, 1);

      // zero-wait throughput and no spurious writes once drained
      wr_q.delete();
      ack_wait = 0;
      stream(6, 30'h300, acc, st);
      check("rate_accepted", acc, 6);
      wait_writes(6);
      for (int i = 1; i < 6 && i < wr_q.size(); i++) check("rate_2cyc", wr_q[i].cyc - wr_q[i-1].cyc, 2);
      repeat (10) @(negedge clk);
      #2;
      check("rate_no_extra_write", wr_q.size(), 6);
      check("rate_stb_idle", mwb_stb_o, 0);
      if (wr_q.size() == 6) check("rate_last_adr", wr_q[5].adr, exp_adr(30'h300, 5));

      // frame shorter than the pixel stream
      wr_q.delete();
      d0 = done_cnt;
      start_frame(5);
      stream(7, 30'h400, acc, st);
      check("fc_accepted", acc, 7);
      wait_writes(7);
      for (int i = 0; i < 7 && wr_q.size() > 0; i++) begin
         r = wr_q.pop_front();
         check("fc_adr", r.adr, exp_adr(30'h400, i));
         check("fc_flags", {r.done, r.busy}, i < 4 ? 2'b01 : (i == 4 ? 2'b10 : 2'b00));
      end
      check("fc_done_once", done_cnt - d0, 1);

      // start while busy is ignored
      wr_q.delete();
      d0 = done_cnt;
      start_frame(3);
      stream(1, 30'h500, acc, st);
      start_frame(9);
      check("sb_busy", busy, 1);
      stream(3, 30'h501, acc, st);
      check("sb_accepted", acc, 3);
      wait_writes(4);
      for (int i = 0; i < 4 && wr_q.size() > 0; i++) begin
         r = wr_q.pop_front();
         check("sb_flags", {r.done, r.busy}, i < 2 ? 2'b01 : (i == 2 ? 2'b10 : 2'b00));
      end
      check("sb_done_once", done_cnt - d0, 1);

      // reset in the middle of a stalled write
      wr_q.delete();
      slave_en = 0;
      d0 = done_cnt;
      start_frame(4);
      stream(RST_PUSH, 30'h600, acc, st);
      check("rm_accepted", acc, RST_PUSH);
      check("rm_stb_before", mwb_stb_o, 1);
      dc_ready = 1;
      #2;
      rst = 1;
      #1;
      check("rm_stb_async", {mwb_stb_o, mwb_cyc_o, mwb_we_o}, 3'b000);
      check("rm_adr", mwb_adr_o, 0);
      check("rm_dat", mwb_dat_o, 0);
      check("rm_busy_done", {busy, done}, 2'b00);
      check("rm_dc_next", dc_next, 0);
      @(negedge clk);
      rst = 0;
      dc_ready = 0;
      slave_en = 1;
      repeat (20) @(negedge clk);
      #2;
      check("rm_no_writes", wr_q.size(), 0);
      check("rm_no_done", done_cnt - d0, 0);
      check("rm_idle", {mwb_stb_o, busy}, 2'b00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/writedest.md
# writedest

Destination pixel write-back stage of the image warping and decay pipeline. Accepts finished 24-bit pixels with their destination word address from the upstream stage through the pipeline ready/next handshake. Posts them into an internal buffer and writes them to memory as a write-only WISHBONE master. Counts acknowledged writes against a per-frame pixel count and signals frame completion.

## Interface
- Parameters: none (buffer depth is fixed by the configuration macro).
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse; begins a frame, loads npixels.
- npixels  in  20  pixels in the frame; sampled only on start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the frame's last write is acknowledged.
- dc_ready  in  1  upstream has a valid pixel on d_addr/d_data.
- dc_next  out  1  pixel consumed this cycle (combinational).
- d_addr  in  30  destination word address.
- d_data  in  24  destination pixel, RGB888.
- mwb_adr_o  out  32  byte address, {addr, 2'b00}.
- mwb_dat_o  out  32  {8'h00, data}.
- mwb_sel_o  out  4  constant 4'b1111.
- mwb_we_o  out  1  equals mwb_stb_o.
- mwb_cyc_o  out  1  equals mwb_stb_o.
- mwb_stb_o  out  1  write strobe, registered.
- mwb_ack_i  in  1  slave acknowledge.

## Operation
- Buffer holds {addr[29:0], data[23:0]} entries, depth D: D=4 with FIFO enabled, D=1 without.
- Push: dc_next = dc_ready & ~full. When dc_next=1, the entry is written at the clock edge. A pop on the same edge does not free space for that cycle's push.
- Write FSM, two states:
  - IDLE: if the buffer is non-empty, load the adr/dat output registers from the head, pop, set stb, and go to WRITE. Otherwise stay.
  - WRITE: hold stb, adr and dat stable until mwb_ack_i. On ack, clear stb and go to IDLE.
- Frame counter, 20 bits:
  - On start while not busy: remaining <= npixels; busy <= 1.
  - start while busy is ignored.
  - Each ack while busy decrements remaining. An ack that takes remaining 1->0 raises done for one cycle and clears busy.
  - npixels=0: done pulses the cycle after start; busy never rises.
  - Acks while not busy are written normally and not counted.
- Reset values: busy=0, done=0, mwb_stb_o/cyc/we=0, mwb_adr_o=0, mwb_dat_o=0, buffer empty, remaining=0, FSM=IDLE. dc_next is 0 while rst is held.
- Reset mid-transfer: stb drops asynchronously, the in-flight write and buffered entries are discarded, and no done pulse is generated.

## Timing
- Pixel accepted at edge N: stb high from edge N+1 when the buffer was empty and the FSM idle. Minimum occupancy is 2 cycles per write: WRITE with ack in the same cycle, then IDLE.
- Sustained throughput is 1 pixel / 2 cycles with zero-wait acks; each slave wait state adds 1 cycle.
- done is registered and asserts in the cycle after the final ack edge.
- mwb_adr_o/mwb_dat_o change only on the IDLE->WRITE transition.

## Configuration
- WRITEDEST_FIFO_EN defined: 4-entry circular buffer with 2-bit read/write pointers and a 3-bit level; full is level==4.
- Not defined: single holding register with a valid bit; full is valid. Upstream stalls while a write is outstanding. The port list is identical in both builds.

## Structure
- Shared package: pixel width (24), word-address width (30), frame-count width (20), and the FSM state encoding (IDLE/WRITE).
- One sub-module, writedest_fifo: synchronous FIFO with push/pop/full/empty, depth selected by WRITEDEST_FIFO_EN. The FSM and the counter stay in writedest.

## Test plan
- Single pixel, zero-wait slave: d_addr=30'h100, d_data=24'hABCDEF, start with npixels=1. Required: mwb_adr_o=32'h400, mwb_dat_o=32'h00ABCDEF, sel=4'hF, we=cyc=stb=1 for one cycle, then done pulses once and busy falls.
- Burst with a stalling slave: 8 pixels offered continuously, ack delayed 3 cycles per write.
  - FIFO build: dc_next drops after 4+1 entries are held.
  - Non-FIFO build: dc_next drops after 1 entry.
  - Both builds: addresses are written in order and adr/dat stay stable while waiting.
- Frame count: npixels=5, 7 pixels written. Required: done on the 5th ack only; the 6th and 7th are written with busy=0. Also: npixels=0 gives a done pulse the cycle after start.
- start while busy: second start mid-frame with npixels=9, first frame npixels=3. Required: done after the 3rd ack and the second start ignored.
- Reset mid-write: assert rst while stb=1 and 3 entries are buffered. Required: stb=0 asynchronously, no further writes after release, done never pulses, and all outputs are at reset values.
- Empty/full boundary: dc_ready held with the slave acking immediately. Required: 1 pixel per 2 cycles, dc_next never asserted when full, and no write issued when the buffer is empty.
